// File: rtl/flappy_pkg.sv
// Shared constants, types and bus helpers for the FlappyDash pixel renderer.
package flappy_pkg;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned MAX_PILLARS = 8;
    localparam int unsigned BUS_W       = COORD_W * MAX_PILLARS;

    localparam logic [11:0] DEF_BALL_RGB   = 12'hFFF;
    localparam logic [11:0] DEF_PILLAR_RGB = 12'h0F0;
    localparam logic [11:0] DEF_BG_RGB     = 12'h000;
    localparam logic [11:0] DEF_FLASH_RGB  = 12'hF00;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [11:0]        rgb_t;

    // Callers widen their packed bus to BUS_W so one helper serves any pillar count.
    function automatic coord_t pillar_coord(input logic [BUS_W-1:0] bus, input int unsigned idx);
        return bus[idx*COORD_W +: COORD_W];
    endfunction

endpackage

// File: rtl/flappy_pillar_hit.sv
// Combinational hit test for one pillar: solid column except for a vertical gap.
module flappy_pillar_hit
    import flappy_pkg::*;
#(
    parameter int unsigned ACTIVE_WIDTH = SCREEN_W,
    parameter int unsigned PILLAR_WIDTH = 50,
    parameter int unsigned GAP_HEIGHT   = 80
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] px,
    input  logic [9:0] gy,
    output logic       hit
);

    // 11-bit operands so px+width and gy+gap never wrap.
    logic [10:0] x11, y11, px11, gy11;

    assign x11  = {1'b0, x};
    assign y11  = {1'b0, y};
    assign px11 = {1'b0, px};
    assign gy11 = {1'b0, gy};

    assign hit = (px11 < 11'(ACTIVE_WIDTH))
              && (x11 >= px11)
              && (x11 < px11 + 11'(PILLAR_WIDTH))
              && ((y11 < gy11) || (y11 >= gy11 + 11'(GAP_HEIGHT)));

endmodule

// File: rtl/flappy_render_pipe.sv
// Two-stage pipelined FlappyDash renderer with per-frame shadowing, collision
// reporting and a game-over flash on the ball.
module flappy_render_pipe
    import flappy_pkg::*;
#(
    parameter int unsigned ACTIVE_WIDTH  = SCREEN_W,
    parameter int unsigned ACTIVE_HEIGHT = SCREEN_H,
    parameter int unsigned NUM_PILLARS   = 3,
    parameter int unsigned BALL_X        = SCREEN_W / 3,
    parameter int unsigned BALL_SIZE     = 10,
    parameter int unsigned PILLAR_WIDTH  = 50,
    parameter int unsigned GAP_HEIGHT    = 80,
    parameter logic [11:0] BALL_RGB      = DEF_BALL_RGB,
    parameter logic [11:0] PILLAR_RGB    = DEF_PILLAR_RGB,
    parameter logic [11:0] BG_RGB        = DEF_BG_RGB,
    parameter logic [11:0] FLASH_RGB     = DEF_FLASH_RGB,
    parameter int unsigned FLASH_SHIFT   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      frame_start,
    input  logic [9:0]                ball_y,
    input  logic [10*NUM_PILLARS-1:0] pillar_x,
    input  logic [10*NUM_PILLARS-1:0] pillar_gap_y,
    input  logic                      game_over,
    output logic [3:0]                r,
    output logic [3:0]                g,
    output logic [3:0]                b,
    output logic                      out_valid,
    output logic                      collision,
    output logic                      collision_valid
);

    localparam int unsigned PW = COORD_W * NUM_PILLARS;

    // Shadow state, sampled once per frame
    coord_t          ball_y_q;
    logic [PW-1:0]   px_q, gy_q;
    logic            go_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [BUS_W-1:0] px_bus, gy_bus;

    // Frame index while game_over stays high; restarts at 0 on the rising frame.
    assign cnt_d = (game_over && go_q) ? cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_y_q <= '1;
            px_q     <= '1;
            gy_q     <= '1;
            go_q     <= 1'b0;
            cnt_q    <= 8'd0;
        end else if (frame_start) begin
            ball_y_q <= ball_y;
            px_q     <= pillar_x;
            gy_q     <= pillar_gap_y;
            go_q     <= game_over;
            cnt_q    <= cnt_d;
        end
    end

    assign px_bus = BUS_W'(px_q);
    assign gy_bus = BUS_W'(gy_q);

    logic [NUM_PILLARS-1:0] hit_vec;

    for (genvar i = 0; i < NUM_PILLARS; i++) begin : g_pillar
        flappy_pillar_hit #(
            .ACTIVE_WIDTH (ACTIVE_WIDTH),
            .PILLAR_WIDTH (PILLAR_WIDTH),
            .GAP_HEIGHT   (GAP_HEIGHT)
        ) u_hit (
            .x   (x),
            .y   (y),
            .px  (pillar_coord(px_bus, i)),
            .gy  (pillar_coord(gy_bus, i)),
            .hit (hit_vec[i])
        );
    end

    logic [10:0] x11, y11, by11;
    logic        in_area, ball_hit_d, pillar_hit_d;

    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};
    assign by11 = {1'b0, ball_y_q};
    assign in_area = (x11 < 11'(ACTIVE_WIDTH)) && (y11 < 11'(ACTIVE_HEIGHT));

    assign ball_hit_d = in_area
                     && (x11 >= 11'(BALL_X)) && (x11 < 11'(BALL_X + BALL_SIZE))
                     && (y11 >= by11) && (y11 < by11 + 11'(BALL_SIZE));
    assign pillar_hit_d = in_area && (|hit_vec);

    // Stage 1: hit classification
    logic s1_valid_q, s1_ball_q, s1_pillar_q, s1_crash;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_ball_q   <= 1'b0;
            s1_pillar_q <= 1'b0;
        end else begin
            s1_valid_q  <= pix_valid;
            s1_ball_q   <= ball_hit_d;
            s1_pillar_q <= pillar_hit_d;
        end
    end

    assign s1_crash = s1_valid_q && s1_ball_q && s1_pillar_q;

    // Stage 2: colour resolve
    rgb_t rgb_d, rgb_q;
    logic out_valid_q;

    always_comb begin
        rgb_d = BG_RGB;
        if (!s1_valid_q) begin
            rgb_d = '0;
        end else if (s1_ball_q) begin
            rgb_d = (go_q && cnt_q[FLASH_SHIFT]) ? FLASH_RGB : BALL_RGB;
        end else if (s1_pillar_q) begin
            rgb_d = PILLAR_RGB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            out_valid_q <= s1_valid_q;
        end
    end

    // A crash sitting in S1 on the frame_start cycle belongs to the frame being reported.
    logic acc_q, collision_q, collision_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q             <= 1'b0;
            collision_q       <= 1'b0;
            collision_valid_q <= 1'b0;
        end else begin
            collision_valid_q <= frame_start;
            if (frame_start) begin
                collision_q <= acc_q | s1_crash;
                acc_q       <= 1'b0;
            end else if (s1_crash) begin
                acc_q <= 1'b1;
            end
        end
    end

    assign r               = rgb_q[11:8];
    assign g               = rgb_q[7:4];
    assign b               = rgb_q[3:0];
    assign out_valid       = out_valid_q;
    assign collision       = collision_q;
    assign collision_valid = collision_valid_q;

endmodule

// File: tb/tb_flappy_render_pipe.sv
// Self-checking bench for flappy_render_pipe: directed vectors plus randomized
// frames checked against a behavioural scene model.
module tb_flappy_render_pipe;

    localparam int NP = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            pix_valid;
    logic [9:0]      x, y;
    logic            frame_start;
    logic [9:0]      ball_y;
    logic [10*NP-1:0] pillar_x, pillar_gap_y;
    logic            game_over;
    logic [3:0]      r, g, b;
    logic            out_valid, collision, collision_valid;

    always #5 clk = ~clk;

    flappy_render_pipe #(.NUM_PILLARS(NP)) dut (
        .clk             (clk),
        .reset           (reset),
        .pix_valid       (pix_valid),
        .x               (x),
        .y               (y),
        .frame_start     (frame_start),
        .ball_y          (ball_y),
        .pillar_x        (pillar_x),
        .pillar_gap_y    (pillar_gap_y),
        .game_over       (game_over),
        .r               (r),
        .g               (g),
        .b               (b),
        .out_valid       (out_valid),
        .collision       (collision),
        .collision_valid (collision_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scene model: what is on screen this frame, and what was reported last frame
    int          m_ball;
    int          m_px[NP];
    int          m_gy[NP];
    bit          m_go;
    int          m_frame;
    bit          m_acc;
    bit          m_coll;
    bit          prev_pv;
    logic [11:0] prev_rgb;

    typedef struct {
        string       name;
        int          xx;
        int          yy;
        logic [11:0] rgb;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit ball_at(int xx, int yy);
        return xx >= 213 && xx < 223 && yy >= m_ball && yy < m_ball + 10;
    endfunction

    function automatic bit pillar_at(int xx, int yy);
        for (int i = 0; i < NP; i++)
            if (m_px[i] < 640 && xx >= m_px[i] && xx < m_px[i] + 50 &&
                (yy < m_gy[i] || yy >= m_gy[i] + 80))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] colour(bit pv, int xx, int yy);
        if (!pv) return 12'h000;
        if (ball_at(xx, yy)) return (m_go && ((m_frame / 8) % 2 == 1)) ? 12'hF00 : 12'hFFF;
        if (pillar_at(xx, yy)) return 12'h0F0;
        return 12'h000;
    endfunction

    task automatic model_reset();
        m_ball = 1023;
        for (int i = 0; i < NP; i++) begin
            m_px[i] = 1023;
            m_gy[i] = 1023;
        end
        m_go     = 1'b0;
        m_frame  = 0;
        m_acc    = 1'b0;
        m_coll   = 1'b0;
        prev_pv  = 1'b0;
        prev_rgb = 12'h000;
    endtask

    // One pixel clock: drive, advance the model, then compare against the pixel
    // presented one step earlier (2-cycle latency from presentation).
    task automatic step(input bit pv, input int xx, input int yy, input bit fs);
        logic [11:0] e;
        bit          crash;
        pix_valid   = pv;
        x           = xx[9:0];
        y           = yy[9:0];
        frame_start = fs;
        e     = colour(pv, xx, yy);
        crash = pv && ball_at(xx, yy) && pillar_at(xx, yy);
        if (fs) begin
            m_coll  = m_acc;
            m_acc   = 1'b0;
            m_frame = (game_over && m_go) ? (m_frame + 1) % 256 : 0;
            m_go    = game_over;
            m_ball  = int'(ball_y);
            for (int i = 0; i < NP; i++) begin
                m_px[i] = int'(pillar_x[10*i +: 10]);
                m_gy[i] = int'(pillar_gap_y[10*i +: 10]);
            end
        end
        if (crash) m_acc = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid", out_valid, prev_pv);
        check("rgb", {r, g, b}, prev_rgb);
        check("collision_valid", collision_valid, fs);
        check("collision", collision, m_coll);
        prev_pv  = pv;
        prev_rgb = e;
    endtask

    task automatic px_check(input string name, input int xx, input int yy, input logic [11:0] exp);
        step(1'b1, xx, yy, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check(name, {r, g, b}, exp);
    endtask

    task automatic set_inputs(input int by, input int p0x, input int p0g, input bit go);
        ball_y       = by[9:0];
        pillar_x     = '1;
        pillar_gap_y = '1;
        pillar_x[9:0]     = p0x[9:0];
        pillar_gap_y[9:0] = p0g[9:0];
        game_over    = go;
    endtask

    task automatic scene(input int by, input int p0x, input int p0g, input bit go);
        set_inputs(by, p0x, p0g, go);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                step(1'b1, xx, yy, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        vt[0]  = '{"ball_in",       215, 105, 12'hFFF};
        vt[1]  = '{"pillar_body",   310, 150, 12'h0F0};
        vt[2]  = '{"gap_top_row",   310, 200, 12'h000};
        vt[3]  = '{"gap_end",       310, 280, 12'h0F0};
        vt[4]  = '{"above_gap",     310, 199, 12'h0F0};
        vt[5]  = '{"gap_last_row",  310, 279, 12'h000};
        vt[6]  = '{"ball_left_out", 212, 105, 12'h000};
        vt[7]  = '{"ball_right_out",223, 105, 12'h000};
        vt[8]  = '{"ball_below",    215, 110, 12'h000};
        vt[9]  = '{"pillar_right",  349, 150, 12'h0F0};
        vt[10] = '{"pillar_past",   350, 150, 12'h000};
        vt[11] = '{"origin_bg",       0,   0, 12'h000};

        reset       = 1'b1;
        pix_valid   = 1'b1;
        x           = '0;
        y           = '0;
        frame_start = 1'b0;
        set_inputs(0, 0, 0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_rgb", {r, g, b}, 12'h000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_collision", collision, 1'b0);
        check("rst_collision_valid", collision_valid, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 1'b0);

        // Directed pixels against one scene
        scene(100, 300, 200, 1'b0);
        foreach (vt[i]) px_check(vt[i].name, vt[i].xx, vt[i].yy, vt[i].rgb);

        // Pixel in the frame_start cycle still sees the old ball position
        set_inputs(300, 300, 200, 1'b0);
        step(1'b1, 215, 105, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        check("shadow_old", {r, g, b}, 12'hFFF);
        px_check("shadow_new_gone", 215, 105, 12'h000);
        px_check("shadow_new_ball", 215, 305, 12'hFFF);

        // Right-edge and off-screen pillars
        scene(1000, 620, 200, 1'b0);
        px_check("edge_639", 639, 0, 12'h0F0);
        px_check("edge_nowrap", 0, 0, 12'h000);
        px_check("edge_619", 619, 0, 12'h000);
        scene(1000, 1023, 0, 1'b0);
        px_check("offscreen_pillar", 630, 300, 12'h000);

        // Collision frame, then a clean frame
        scene(100, 210, 300, 1'b0);
        scan(205, 225, 95, 112);
        set_inputs(100, 210, 50, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        check("coll_set", collision, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        check("coll_valid_pulse", collision_valid, 1'b0);
        scan(205, 225, 95, 112);
        step(1'b0, 0, 0, 1'b1);
        check("coll_clear", collision, 1'b0);

        // Crash still in S1 on the frame_start cycle is reported for the old frame
        scene(100, 210, 300, 1'b0);
        step(1'b1, 215, 105, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        check("coll_late_hit", collision, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        check("coll_late_next", collision, 1'b0);

        // Asynchronous reset mid-frame drops the pending report
        scene(100, 210, 300, 1'b0);
        scan(210, 222, 100, 109);
        step(1'b1, 215, 105, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("abort_rgb", {r, g, b}, 12'h000);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_collision", collision, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 0, 0, 1'b1);
        check("abort_no_report", collision, 1'b0);

        // Flash cadence while game over
        for (int f = 0; f < 16; f++) begin
            scene(100, 1023, 1023, 1'b1);
            px_check($sformatf("flash_f%0d", f), 215, 105, (f < 8) ? 12'hFFF : 12'hF00);
        end
        scene(100, 1023, 1023, 1'b0);
        px_check("flash_off", 215, 105, 12'hFFF);

        // Randomized frames against the model
        for (int fr = 0; fr < 25; fr++) begin
            ball_y    = 10'($urandom_range(0, 470));
            game_over = 1'($urandom_range(0, 1));
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 4) == 0)
                    pillar_x[10*i +: 10] = 10'($urandom_range(640, 1023));
                else if ($urandom_range(0, 1) == 0)
                    pillar_x[10*i +: 10] = 10'($urandom_range(160, 230));
                else
                    pillar_x[10*i +: 10] = 10'($urandom_range(0, 639));
                pillar_gap_y[10*i +: 10] = 10'($urandom_range(0, 470));
            end
            step(1'b0, 0, 0, 1'b1);
            step(1'b0, 0, 0, 1'b0);
            step(1'b0, 0, 0, 1'b0);
            for (int p = 0; p < 300; p++) begin
                int xx, yy;
                if ($urandom_range(0, 1) == 0) begin
                    xx = $urandom_range(200, 235);
                    yy = int'(ball_y) + $urandom_range(0, 14) - 2;
                    if (yy < 0) yy = 0;
                    if (yy > 479) yy = 479;
                end else begin
                    xx = $urandom_range(0, 639);
                    yy = $urandom_range(0, 479);
                end
                step($urandom_range(0, 3) != 0, xx, yy, 1'b0);
            end
            step(1'b0, 0, 0, 1'b0);
            step(1'b0, 0, 0, 1'b0);
        end
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
